adder_arbiter: RTL and testbench
================================

Name: adder_arbiter

Overview:
- Shares one ripple_cla8 adder between two requesters: port 0 (ALU add path) and port 1 (PC/address incrementer).
- Round-robin arbitration; drives the adder's en/A/B/c_in handshake and waits for ready.
- Returns the registered sum and carry with a one-cycle done pulse to the winning requester.
- Includes a ready-timeout watchdog so a hung adder cannot stall the machine.

Parameters:
- WIDTH, 8, operand/result width; must match the adder.
- TIMEOUT, 16, max cycles en is held high waiting for add_ready before aborting.
- CW, 5, watchdog counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 request; held with operands until done0/err0.
- a0, b0  in  WIDTH  requester 0 operands.
- cin0  in  1  requester 0 carry-in.
- done0  out  1  one-cycle pulse: result/cout valid for requester 0.
- err0  out  1  one-cycle pulse: requester 0 operation timed out.
- req1, a1, b1, cin1, done1, err1  as above, requester 1.
- result  out  WIDTH  registered sum of the last completed operation.
- cout  out  1  registered carry-out of the last completed operation.
- busy  out  1  high in any state other than IDLE.
- add_en  out  1  adder enable.
- add_a, add_b  out  WIDTH  adder operands.
- add_cin  out  1  adder carry-in.
- add_out  in  WIDTH  adder sum.
- add_cout  in  1  adder carry-out.
- add_ready  in  1  adder result valid; qualified only while add_en=1.

Behaviour:
- Reset: state=IDLE; add_en=0; add_a/add_b/add_cin/result/cout=0; done*/err*/busy=0; rr pointer=0 (requester 0 preferred); watchdog=0. Reset mid-operation aborts immediately; no done/err is issued for the aborted operation.
- IDLE:
  - Sample req0/req1.
  - If both are high, grant the requester named by the rr pointer.
  - If one is high, grant it.
  - On a grant: latch that requester's a/b/cin into add_a/add_b/add_cin, record the owner, set add_en=1, clear the watchdog, go BUSY.
- BUSY: add_en=1; operands held stable; watchdog increments each cycle.
  - add_ready=1: latch add_out into result and add_cout into cout; pulse done<owner> for one cycle; add_en=0; rr pointer=other requester; go RELEASE.
  - Watchdog reaches TIMEOUT-1 without ready: pulse err<owner>; result/cout unchanged; add_en=0; rr pointer=other requester; go RELEASE.
  - If ready and timeout coincide, ready wins.
- RELEASE: add_en=0. Stay until add_ready=0, then go IDLE. add_en is low for at least 1 cycle between operations.
- Latency, adder readying 1 cycle after en:
  - Edge 0: req sampled in IDLE.
  - Edge 1: add_en high.
  - Edge 2: ready sampled high; done asserted after edge 2.
  - Edge 3 earliest: next IDLE arbitration.
- Requester protocol:
  - Hold req and operands until done/err.
  - Deassert req in the cycle following done/err.
  - A req still high when IDLE samples it is a new request.
  - Dropping req while owned is a violation; the operation still completes and done is still pulsed.
- Fairness: with both requesters continuously requesting, grants alternate 0,1,0,1.
- done0/done1/err0/err1 are mutually exclusive and never high simultaneously.
- No width growth: result is WIDTH bits; overflow is reported only via cout.

Decomposition:
- Shared package/header: state encodings (IDLE=2'd0, BUSY=2'd1, RELEASE=2'd2), default TIMEOUT, WIDTH=8.
- One natural sub-module, rr_pick2: combinational 2-way round-robin select from req0, req1 and the pointer. Outputs grant_valid and grant_id.
- FSM, operand muxing and watchdog stay in adder_arbiter.

Test Plan:
- Single request: req0, a0=12, b0=1, cin0=0, with a real ripple_cla8 → add_en high 1 cycle after sampling; done0 pulse; result=13 (0x0D), cout=0; done1 never asserted.
- Carry case: req1, a1=0xFF, b1=0x01, cin1=1 → result=0x01, cout=1; done1 only.
- Contention: req0 and req1 both held from reset → first grant to 0, then 1, then 0 (alternating done0/done1); add_en drops for ≥1 cycle between operations.
- Timeout: adder stub keeps add_ready=0, req0 → err0 pulses exactly TIMEOUT cycles after add_en rose; result unchanged; add_en=0; next grant goes to requester 1.
- Reset mid-operation: assert rst while in BUSY → on the next edge add_en=0, busy=0, no done/err; the following request is served with requester 0 preferred.
- Stuck-ready stub: add_ready held 1 after done → arbiter stays in RELEASE and busy=1 until add_ready falls, then serves the next pending request.

Source files
------------

// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the two-port adder arbiter: state encoding,
// default sizing and a small helper for the round-robin pointer.
package adder_arbiter_pkg;

   localparam int ARB_WIDTH   = 8;
   localparam int ARB_TIMEOUT = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   // After a requester is served, the other one becomes preferred.
   function automatic logic other_id(input logic id);
      return ~id;
   endfunction

endpackage

// File: rtl/adder_arbiter_rr_pick2.sv
// Two-way round-robin selector. When both requesters are asking, the
// pointer decides; otherwise the single active requester wins.
module rr_pick2 (
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_ptr,
   output logic o_grant_valid,
   output logic o_grant_id
);

   // Pure combinational pick; the caller registers the outcome.
   always_comb begin
      o_grant_valid = i_req0 | i_req1;
      if (i_req0 && i_req1) begin
         o_grant_id = i_ptr;
      end else begin
         o_grant_id = i_req1;
      end
   end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder between an ALU port (0) and an address-increment
// port (1). Round-robin grant, registered result, one-cycle done/err
// pulse to the owner, and a watchdog that aborts a hung adder.
//
// Adder handshake: add_en is a request held high with stable operands
// until add_ready is seen high on a rising edge (ready is only meaningful
// while add_en=1). After completion add_en stays low and the arbiter
// waits for add_ready to fall before it will arbitrate again.
module adder_arbiter
   import adder_arbiter_pkg::*;
#(
   parameter int WIDTH   = ARB_WIDTH,
   parameter int TIMEOUT = ARB_TIMEOUT,
   parameter int CW      = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             cin0,
   output logic             done0,
   output logic             err0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  logic             cin1,
   output logic             done1,
   output logic             err1,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             busy,
   output logic             add_en,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_cin,
   input  logic [WIDTH-1:0] add_out,
   input  logic             add_cout,
   input  logic             add_ready,
   output logic [1:0]       dbg_state
);

   // Last watchdog value before the operation is abandoned.
   localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

   state_t           r_state;
   logic             r_owner;
   logic             r_ptr;
   logic [CW-1:0]    r_wd;
   logic             r_add_en;
   logic [WIDTH-1:0] r_add_a;
   logic [WIDTH-1:0] r_add_b;
   logic             r_add_cin;
   logic [WIDTH-1:0] r_result;
   logic             r_cout;
   logic             r_done0;
   logic             r_done1;
   logic             r_err0;
   logic             r_err1;

   logic             w_grant_valid;
   logic             w_grant_id;

   rr_pick2 u_pick (
      .i_req0        (req0),
      .i_req1        (req1),
      .i_ptr         (r_ptr),
      .o_grant_valid (w_grant_valid),
      .o_grant_id    (w_grant_id)
   );

   // Arbitration FSM, operand latch, watchdog and result/pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_owner   <= 1'b0;
         r_ptr     <= 1'b0;
         r_wd      <= '0;
         r_add_en  <= 1'b0;
         r_add_a   <= '0;
         r_add_b   <= '0;
         r_add_cin <= 1'b0;
         r_result  <= '0;
         r_cout    <= 1'b0;
         r_done0   <= 1'b0;
         r_done1   <= 1'b0;
         r_err0    <= 1'b0;
         r_err1    <= 1'b0;
      end else begin
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;
         r_err0  <= 1'b0;
         r_err1  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_grant_valid) begin
                  r_owner   <= w_grant_id;
                  r_add_a   <= w_grant_id ? a1   : a0;
                  r_add_b   <= w_grant_id ? b1   : b0;
                  r_add_cin <= w_grant_id ? cin1 : cin0;
                  r_add_en  <= 1'b1;
                  r_wd      <= '0;
                  r_state   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // Ready is checked first so it wins over a same-cycle timeout.
               if (add_ready) begin
                  r_result <= add_out;
                  r_cout   <= add_cout;
                  r_done0  <= ~r_owner;
                  r_done1  <= r_owner;
                  r_add_en <= 1'b0;
                  r_ptr    <= other_id(r_owner);
                  r_state  <= ST_RELEASE;
               end else if (r_wd == WD_LAST) begin
                  r_err0   <= ~r_owner;
                  r_err1   <= r_owner;
                  r_add_en <= 1'b0;
                  r_ptr    <= other_id(r_owner);
                  r_state  <= ST_RELEASE;
               end else begin
                  r_wd <= r_wd + CW'(1);
               end
            end
            ST_RELEASE: begin
               r_add_en <= 1'b0;
               if (!add_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_add_en <= 1'b0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign done0     = r_done0;
   assign done1     = r_done1;
   assign err0      = r_err0;
   assign err1      = r_err1;
   assign result    = r_result;
   assign cout      = r_cout;
   assign busy      = (r_state != ST_IDLE);
   assign add_en    = r_add_en;
   assign add_a     = r_add_a;
   assign add_b     = r_add_b;
   assign add_cin   = r_add_cin;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: behavioural adder stub (normal / hung /
// stuck-ready), transaction-level reference model feeding an expected
// queue, and a monitor that pops on every done/err pulse.
module tb_adder_arbiter;

   localparam int W  = 8;
   localparam int TO = 16;

   // ---------------- clock / reset / DUT ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         req0, req1, cin0, cin1;
   logic [W-1:0] a0, b0, a1, b1;
   logic         done0, done1, err0, err1;
   logic [W-1:0] result;
   logic         cout, busy, add_en, add_cin;
   logic [W-1:0] add_a, add_b;
   logic [W-1:0] add_out;
   logic         add_cout, add_ready;
   logic [1:0]   dbg_state;

   adder_arbiter #(.WIDTH(W), .TIMEOUT(TO), .CW(5)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .a0(a0), .b0(b0), .cin0(cin0), .done0(done0), .err0(err0),
      .req1(req1), .a1(a1), .b1(b1), .cin1(cin1), .done1(done1), .err1(err1),
      .result(result), .cout(cout), .busy(busy),
      .add_en(add_en), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_out(add_out), .add_cout(add_cout), .add_ready(add_ready),
      .dbg_state(dbg_state)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- adder stub ----------------
   // mode 0: ready after stub_lat cycles of en; 1: never ready;
   // 2: like 0 but ready lingers stub_hold cycles after en falls.
   int stub_mode = 0;
   int stub_lat  = 1;
   int stub_hold = 0;
   int lat_cnt, hold_cnt;

   always @(posedge clk) begin
      if (rst) begin
         add_ready <= 1'b0;
         add_out   <= '0;
         add_cout  <= 1'b0;
         lat_cnt   <= 0;
         hold_cnt  <= 0;
      end else if (add_en) begin
         if (!add_ready && stub_mode != 1) begin
            if (lat_cnt + 1 >= stub_lat) begin
               add_ready             <= 1'b1;
               {add_cout, add_out}   <= 9'(add_a) + 9'(add_b) + 9'(add_cin);
               hold_cnt              <= (stub_mode == 2) ? stub_hold : 0;
            end else begin
               lat_cnt <= lat_cnt + 1;
            end
         end
      end else begin
         lat_cnt <= 0;
         if (add_ready) begin
            if (hold_cnt > 0) hold_cnt <= hold_cnt - 1;
            else              add_ready <= 1'b0;
         end
      end
   end

   // ---------------- reference model + scoreboard ----------------
   // Entry layout: {is_err, owner, cout, result}
   logic [10:0] exp_q[$];
   bit          m_ptr;
   logic [W-1:0] m_res;
   logic        m_cout;

   function automatic void predict(input bit id, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic c,
                                   input bit hang);
      logic [8:0] s;
      if (!hang) begin
         s = {1'b0, x} + {1'b0, y} + {8'b0, c};
         m_res  = s[7:0];
         m_cout = s[8];
      end
      m_ptr = ~id;
      exp_q.push_back({hang, id, m_cout, m_res});
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // Monitor: every completion pulse is matched against the queue.
   logic [10:0] mon_got, mon_exp;
   always @(negedge clk) begin
      if (!rst && (done0 || done1 || err0 || err1)) begin
         checks++;
         if ($countones({done0, done1, err0, err1}) != 1) begin
            errors++;
            $display("FAIL pulse_excl d0=%b d1=%b e0=%b e1=%b want one-hot", done0, done1, err0, err1);
         end
         checks++;
         if (add_en !== 1'b0) begin
            errors++;
            $display("FAIL en_low_on_pulse got=%b want=0", add_en);
         end
         mon_got = {err0 | err1, done1 | err1, cout, result};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse got=%h want=none", mon_got);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               errors++;
               $display("FAIL completion got err/id/cout/res=%b/%b/%b/%h want %b/%b/%b/%h",
                        mon_got[10], mon_got[9], mon_got[8], mon_got[7:0],
                        mon_exp[10], mon_exp[9], mon_exp[8], mon_exp[7:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk);
      rst  = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_ptr  = 1'b0;
      m_res  = '0;
      m_cout = 1'b0;
      exp_q.delete();
   endtask

   task automatic run_round(input bit r0, input bit r1,
                            input logic [W-1:0] x0, input logic [W-1:0] y0, input logic c0,
                            input logic [W-1:0] x1, input logic [W-1:0] y1, input logic c1,
                            input int mode, input int hold, output int en_cycles);
      bit pend0, pend1, first;
      int budget;
      // let the arbiter return to IDLE so grant timing is deterministic
      budget = 0;
      while (busy && budget < 60) begin
         @(negedge clk);
         budget++;
      end
      if (busy) begin
         checks++; errors++;
         $display("FAIL idle_wait got busy=1 want 0");
      end
      stub_mode = mode;
      stub_lat  = $urandom_range(1, 3);
      stub_hold = hold;
      a0 = x0; b0 = y0; cin0 = c0;
      a1 = x1; b1 = y1; cin1 = c1;
      req0 = r0;
      req1 = r1;
      first = (r0 && r1) ? m_ptr : r1;
      if (first) predict(1'b1, x1, y1, c1, mode == 1);
      else       predict(1'b0, x0, y0, c0, mode == 1);
      if (r0 && r1) begin
         if (first) predict(1'b0, x0, y0, c0, mode == 1);
         else       predict(1'b1, x1, y1, c1, mode == 1);
      end
      pend0 = r0;
      pend1 = r1;
      budget = 0;
      en_cycles = 0;
      while ((pend0 || pend1) && budget < 400) begin
         @(negedge clk);
         budget++;
         if (budget == 1) begin
            chk("grant_en", add_en, 1);
            chk("grant_ops", {add_a, add_b, add_cin},
                first ? {x1, y1, c1} : {x0, y0, c0});
         end
         if (add_en) en_cycles++;
         if (done0 || err0) begin req0 = 1'b0; pend0 = 1'b0; end
         if (done1 || err1) begin req1 = 1'b0; pend1 = 1'b0; end
      end
      if (pend0 || pend1) begin
         checks++; errors++;
         $display("FAIL round_timeout pending=%b%b want 00", pend1, pend0);
         req0 = 1'b0;
         req1 = 1'b0;
      end
   endtask

   // ---------------- main sequence ----------------
   int en_c, bad, n;
   bit rr0, rr1;

   initial begin
      rst = 1'b1;
      req0 = 0; req1 = 0; a0 = 0; b0 = 0; cin0 = 0; a1 = 0; b1 = 0; cin1 = 0;
      do_reset();

      // reset values
      chk("rst_add_en", add_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_state", dbg_state, 0);
      chk("rst_result", {cout, result}, 0);
      chk("rst_add_ops", {add_a, add_b, add_cin}, 0);
      chk("rst_pulses", {done0, done1, err0, err1}, 0);

      // single request and carry case
      run_round(1, 0, 8'd12, 8'd1, 1'b0, 8'h00, 8'h00, 1'b0, 0, 0, en_c);
      run_round(0, 1, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h01, 1'b1, 0, 0, en_c);

      // contention from reset: 0,1,0,1,0,1
      do_reset();
      repeat (3)
         run_round(1, 1, 8'($urandom), 8'($urandom), 1'($urandom),
                   8'($urandom), 8'($urandom), 1'($urandom), 0, 0, en_c);

      // timeout on requester 0, then requester 1 must be preferred
      run_round(1, 0, 8'h11, 8'h22, 1'b0, 8'h00, 8'h00, 1'b0, 1, 0, en_c);
      chk("timeout_en_cycles", en_c, TO);
      run_round(1, 1, 8'h05, 8'h06, 1'b0, 8'h70, 8'h90, 1'b0, 0, 0, en_c);

      // reset in the middle of an operation owned by requester 1
      @(negedge clk);
      stub_mode = 1;
      req1 = 1'b1; a1 = 8'h33; b1 = 8'h44; cin1 = 1'b0;
      repeat (4) @(negedge clk);
      chk("midop_busy", busy, 1);
      chk("midop_en", add_en, 1);
      rst = 1'b1;
      req1 = 1'b0;
      @(negedge clk);
      chk("midrst_en", add_en, 0);
      chk("midrst_busy", busy, 0);
      rst = 1'b0;
      m_ptr = 1'b0; m_res = '0; m_cout = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);
      run_round(1, 1, 8'h01, 8'h02, 1'b1, 8'h10, 8'h20, 1'b0, 0, 0, en_c);

      // stuck ready: arbiter must sit in RELEASE while ready stays high
      run_round(1, 0, 8'h80, 8'h80, 1'b0, 8'h00, 8'h00, 1'b0, 2, 5, en_c);
      bad = 0;
      n = 0;
      while (add_ready && n < 50) begin
         if (!busy || add_en) bad++;
         @(negedge clk);
         n++;
      end
      chk("stuck_busy_held", bad, 0);
      chk("stuck_ready_fell", add_ready, 0);
      chk("stuck_duration", (n >= 5), 1);
      run_round(0, 1, 8'h00, 8'h00, 1'b0, 8'h7F, 8'h01, 1'b0, 0, 0, en_c);

      // randomized traffic
      for (int i = 0; i < 30; i++) begin
         rr0 = 1'($urandom);
         rr1 = 1'($urandom);
         if (!rr0 && !rr1) rr0 = 1'b1;
         run_round(rr0, rr1, 8'($urandom), 8'($urandom), 1'($urandom),
                   8'($urandom), 8'($urandom), 1'($urandom),
                   ($urandom_range(0, 7) == 0) ? 1 : 0, 0, en_c);
      end

      repeat (5) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
